// File: rtl/spiker_adapter_pkg.sv
// Shared definitions for the spiker adapter path: collector FSM states and
// default geometry of the spike vector.
package spiker_adapter_pkg;

  localparam int unsigned N_SPIKES_DEF   = 784;
  localparam int unsigned DATA_WIDTH_DEF = 800;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_SAMPLE   = 2'd1,
    ST_WAIT_RDY = 2'd2
  } collector_state_e;

endpackage

// File: rtl/spiker_collector.sv
// Accumulates single-spike address events into a per-timestep spike vector and
// hands the latched vector to spiker_writer with a one-cycle sample strobe.
module spiker_collector
  import spiker_adapter_pkg::*;
#(
  parameter int unsigned N_SPIKES   = N_SPIKES_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_W     = $clog2(N_SPIKES),
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SCNT_W    = $clog2(N_SPIKES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  spk_valid_i,
  output logic                  spk_ready_o,
  input  logic [ADDR_W-1:0]     spk_addr_i,
  input  logic                  frame_end_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  sample_o,
  input  logic                  writer_ready_i,
  output logic [SCNT_W-1:0]     spike_cnt_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
  output logic                  busy_o,
  output logic                  err_addr_o,
  output logic                  err_ovr_o
);

  if (DATA_WIDTH < N_SPIKES) begin : g_width_check
    $error("spiker_collector: DATA_WIDTH must be >= N_SPIKES");
  end

  localparam logic [ADDR_W:0] NSPK = (ADDR_W + 1)'(N_SPIKES);

  collector_state_e      state_q, state_d;
  logic [N_SPIKES-1:0]   acc_q, acc_d, acc_next;
  logic [SCNT_W-1:0]     cnt_q, cnt_d, cnt_next;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic                  sample_q, sample_d;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic                  erra_q, erra_d;
  logic                  erro_q, erro_d;

  logic accept;
  logic in_range;

  assign spk_ready_o = (state_q == ST_COLLECT) && enable_i && !rst_i;
  assign accept      = spk_valid_i && spk_ready_o;
  assign in_range    = {1'b0, spk_addr_i} < NSPK;

  // Duplicate addresses leave both the vector and the distinct-spike count untouched.
  always_comb begin
    acc_next = acc_q;
    cnt_next = cnt_q;
    if (accept && in_range && !acc_q[spk_addr_i]) begin
      acc_next[spk_addr_i] = 1'b1;
      cnt_next             = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    scnt_d   = scnt_q;
    sample_d = 1'b0;
    fcnt_d   = fcnt_q;
    erra_d   = erra_q;
    erro_d   = erro_q;

    case (state_q)
      ST_COLLECT: begin
        acc_d = acc_next;
        cnt_d = cnt_next;
        // The closing frame includes an event accepted on the same edge.
        if (frame_end_i && enable_i) begin
          data_d                 = '0;
          data_d[N_SPIKES-1:0]   = acc_next;
          scnt_d                 = cnt_next;
          acc_d                  = '0;
          cnt_d                  = '0;
          sample_d               = 1'b1;
          state_d                = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (writer_ready_i) begin
          fcnt_d  = fcnt_q + 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    if (accept && !in_range) begin
      erra_d = 1'b1;
    end
    if (frame_end_i && (state_q != ST_COLLECT)) begin
      erro_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_COLLECT;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      scnt_q   <= '0;
      sample_q <= 1'b0;
      fcnt_q   <= '0;
      erra_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      scnt_q   <= scnt_d;
      sample_q <= sample_d;
      fcnt_q   <= fcnt_d;
      erra_q   <= erra_d;
      erro_q   <= erro_d;
    end
  end

  assign data_out_o  = data_q;
  assign sample_o    = sample_q;
  assign spike_cnt_o = scnt_q;
  assign frame_cnt_o = fcnt_q;
  assign busy_o      = (state_q != ST_COLLECT);
  assign err_addr_o  = erra_q;
  assign err_ovr_o   = erro_q;

endmodule

// File: tb/tb_spiker_collector.sv
// Self-checking bench for spiker_collector: directed scenarios plus a random
// phase, all compared against a set-based behavioural model of the collector.
module tb_spiker_collector;

  localparam int N  = 784;
  localparam int DW = 800;
  localparam int AW = 10;
  localparam int SW = 10;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          spk_valid_i;
  logic          spk_ready_o;
  logic [AW-1:0] spk_addr_i;
  logic          frame_end_i;
  logic [DW-1:0] data_out_o;
  logic          sample_o;
  logic          writer_ready_i;
  logic [SW-1:0] spike_cnt_o;
  logic [CW-1:0] frame_cnt_o;
  logic          busy_o;
  logic          err_addr_o;
  logic          err_ovr_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: the set of spiking neurons for the open frame and the
  // set handed to the writer, plus a three-phase view of the handshake.
  bit            accSet[int];
  bit            latched[int];
  int            latchedCnt;
  int            phase;
  logic [CW-1:0] mFrames;
  bit            mErrA;
  bit            mErrO;
  bit            mSample;

  spiker_collector dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .spk_valid_i    (spk_valid_i),
    .spk_ready_o    (spk_ready_o),
    .spk_addr_i     (spk_addr_i),
    .frame_end_i    (frame_end_i),
    .data_out_o     (data_out_o),
    .sample_o       (sample_o),
    .writer_ready_i (writer_ready_i),
    .spike_cnt_o    (spike_cnt_o),
    .frame_cnt_o    (frame_cnt_o),
    .busy_o         (busy_o),
    .err_addr_o     (err_addr_o),
    .err_ovr_o      (err_ovr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic modelReset();
    accSet.delete();
    latched.delete();
    latchedCnt = 0;
    phase      = 0;
    mFrames    = '0;
    mErrA      = 1'b0;
    mErrO      = 1'b0;
    mSample    = 1'b0;
  endtask

  task automatic modelEdge(input bit en, input bit v, input int addr, input bit fe, input bit wr);
    int old;
    old     = phase;
    mSample = 1'b0;
    if (old == 0) begin
      if (en && v) begin
        if (addr < N) accSet[addr] = 1'b1;
        else          mErrA = 1'b1;
      end
      if (fe && en) begin
        latched    = accSet;
        latchedCnt = accSet.num();
        accSet.delete();
        phase      = 1;
        mSample    = 1'b1;
      end
    end else if (old == 1) begin
      phase = 2;
    end else if (wr) begin
      mFrames = mFrames + 1'b1;
      phase   = 0;
    end
    if (old != 0 && fe) mErrO = 1'b1;
  endtask

  function automatic logic [DW-1:0] expectedVector();
    logic [DW-1:0] v;
    v = '0;
    foreach (latched[k]) v[k] = 1'b1;
    return v;
  endfunction

  function automatic int firstDiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < DW; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic checkVal(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [DW-1:0] ev;
    ev = expectedVector();
    checks++;
    assert (data_out_o === ev)
    else begin
      failures++;
      $error("[TB] FAIL %s data_out observed_popcount=%0d expected_popcount=%0d first_diff_bit=%0d",
             tag, $countones(data_out_o), $countones(ev), firstDiff(data_out_o, ev));
    end
    checkVal({tag, " spk_ready"}, spk_ready_o, (phase == 0) && enable_i);
    checkVal({tag, " sample"},    sample_o,    mSample);
    checkVal({tag, " spike_cnt"}, spike_cnt_o, latchedCnt);
    checkVal({tag, " frame_cnt"}, frame_cnt_o, mFrames);
    checkVal({tag, " busy"},      busy_o,      phase != 0);
    checkVal({tag, " err_addr"},  err_addr_o,  mErrA);
    checkVal({tag, " err_ovr"},   err_ovr_o,   mErrO);
  endtask

  // Drive one cycle of inputs (from a negedge), advance the model on the
  // posedge and compare everything on the following negedge.
  task automatic applyStimulus(input string tag, input bit en, input bit v, input int addr,
                               input bit fe, input bit wr);
    enable_i       = en;
    spk_valid_i    = v;
    spk_addr_i     = AW'(addr);
    frame_end_i    = fe;
    writer_ready_i = wr;
    @(posedge clk_i);
    modelEdge(en, v, addr, fe, wr);
    @(negedge clk_i);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit wr);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 0, 1'b0, wr);
  endtask

  // Reset asserted between edges: outputs must clear at once, and the event
  // port must refuse even with enable and valid high.
  task automatic doReset(input string tag);
    enable_i    = 1'b1;
    spk_valid_i = 1'b1;
    frame_end_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    modelReset();
    checkVal({tag, " rst data"},      data_out_o == '0, 1);
    checkVal({tag, " rst spk_ready"}, spk_ready_o, 0);
    checkVal({tag, " rst sample"},    sample_o, 0);
    checkVal({tag, " rst spike_cnt"}, spike_cnt_o, 0);
    checkVal({tag, " rst frame_cnt"}, frame_cnt_o, 0);
    checkVal({tag, " rst busy"},      busy_o, 0);
    checkVal({tag, " rst errs"},      {err_addr_o, err_ovr_o}, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    checkVal({tag, " rst held spk_ready"}, spk_ready_o, 0);
    rst_i       = 1'b0;
    spk_valid_i = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b1;
    enable_i       = 1'b0;
    spk_valid_i    = 1'b0;
    spk_addr_i     = '0;
    frame_end_i    = 1'b0;
    writer_ready_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("reset state");

    // Mid-cycle reset from an idle block.
    doReset("reset");

    // Basic frame: events 0, 5, 783.
    applyStimulus("basic ev0",   1, 1, 0,   0, 1);
    applyStimulus("basic ev5",   1, 1, 5,   0, 1);
    applyStimulus("basic ev783", 1, 1, 783, 0, 1);
    applyStimulus("basic fe",    1, 0, 0,   1, 1);
    checkVal("basic sample",    sample_o, 1);
    checkVal("basic spike_cnt", spike_cnt_o, 3);
    checkVal("basic bits",      {data_out_o[783], data_out_o[5], data_out_o[0]}, 7);
    checkVal("basic popcount",  $countones(data_out_o), 3);
    applyStimulus("basic wait",  1, 0, 0, 0, 1);
    checkVal("basic sample width", sample_o, 0);
    applyStimulus("basic ret",   1, 0, 0, 0, 1);
    checkVal("basic frame_cnt", frame_cnt_o, 1);

    // Duplicates and an out-of-range address.
    applyStimulus("dup ev5a",  1, 1, 5,   0, 1);
    applyStimulus("dup ev5b",  1, 1, 5,   0, 1);
    applyStimulus("dup ev784", 1, 1, 784, 0, 1);
    applyStimulus("dup fe",    1, 0, 0,   1, 1);
    checkVal("dup spike_cnt", spike_cnt_o, 1);
    checkVal("dup popcount",  $countones(data_out_o), 1);
    checkVal("dup err_addr",  err_addr_o, 1);
    idle("dup drain", 2, 1);

    // Enable low: event and frame end both ignored, no error.
    applyStimulus("disabled", 0, 1, 20, 1, 1);
    checkVal("disabled busy", busy_o, 0);

    // Event accepted together with frame end, then an empty frame.
    applyStimulus("same fe",  1, 1, 10, 1, 1);
    checkVal("same bit10", data_out_o[10], 1);
    idle("same drain", 2, 1);
    applyStimulus("empty fe", 1, 0, 0, 1, 1);
    checkVal("empty data", data_out_o == '0, 1);
    idle("empty drain", 2, 1);

    // Backpressure: writer not ready for 20 cycles, two stray frame ends.
    applyStimulus("bp ev",  1, 1, 42, 0, 0);
    applyStimulus("bp fe",  1, 0, 0,  1, 0);
    for (int i = 0; i < 20; i++)
      applyStimulus("bp hold", 1, 1, 100 + i, (i == 4) || (i == 11), 0);
    checkVal("bp err_ovr", err_ovr_o, 1);
    checkVal("bp bit42",   data_out_o[42], 1);
    applyStimulus("bp release", 1, 0, 0, 0, 1);
    checkVal("bp busy", busy_o, 0);

    // Reset while waiting for the writer.
    applyStimulus("rw ev", 1, 1, 3, 0, 0);
    applyStimulus("rw fe", 1, 0, 0, 1, 0);
    idle("rw wait", 2, 0);
    doReset("rw reset");
    applyStimulus("rw ev7", 1, 1, 7, 1, 0);
    checkVal("rw popcount", $countones(data_out_o), 1);
    checkVal("rw bit7",     data_out_o[7], 1);
    idle("rw ret", 2, 1);
    checkVal("rw frame_cnt", frame_cnt_o, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit en;
      bit v;
      bit fe;
      bit wr;
      int addr;
      en   = ($urandom_range(7) != 0);
      v    = $urandom_range(1);
      addr = ($urandom_range(15) == 0) ? int'($urandom_range(1023, 784)) : int'($urandom_range(783));
      fe   = en && ($urandom_range(24) == 0);
      wr   = $urandom_range(1);
      applyStimulus("random", en, v, addr, fe, wr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spiker_collector.md
# spiker_collector

Upstream stage of `spiker_writer`. It accepts single-spike address events from the SNN core and accumulates them into a `DATA_WIDTH`-bit spike vector for the current timestep. At frame end it presents the vector on `data_out_o` and pulses `sample_o` once. It then waits for `writer_ready_i` before it accepts the next frame.

## Interface

Clocking and reset (already decided): one clock `clk_i`; reset `rst_i` is asynchronous and active-high.

Parameters:
- `N_SPIKES`, 784: number of valid spike addresses.
- `DATA_WIDTH`, 800: output vector width; must be ≥ `N_SPIKES`.
- `ADDR_W`, `$clog2(N_SPIKES)`: event address width.
- `CNT_W`, 16: frame counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  async active-high reset.
- `enable_i`  in  1  collection enable.
- `spk_valid_i`  in  1  spike event valid.
- `spk_ready_o`  out  1  event accept.
- `spk_addr_i`  in  ADDR_W  neuron index of the event.
- `frame_end_i`  in  1  timestep-end strobe.
- `data_out_o`  out  DATA_WIDTH  latched spike vector, to `spiker_writer.data_out_i`.
- `sample_o`  out  1  one-cycle strobe, to `spiker_writer.sample_i`.
- `writer_ready_i`  in  1  from `spiker_writer.writer_ready_o`.
- `spike_cnt_o`  out  `$clog2(N_SPIKES+1)`  distinct spikes in the latched frame.
- `frame_cnt_o`  out  CNT_W  completed frames; wraps.
- `busy_o`  out  1  high when not in COLLECT.
- `err_addr_o`  out  1  sticky: an event was accepted with address ≥ `N_SPIKES`.
- `err_ovr_o`  out  1  sticky: `frame_end_i` arrived outside COLLECT.

## Operation

FSM states: COLLECT, SAMPLE, WAIT_RDY.

COLLECT:
- `spk_ready_o = enable_i` (forced 0 while `rst_i`).
- Handshake: an event is accepted when `spk_valid_i && spk_ready_o`.
- Address < `N_SPIKES`: set the corresponding bit in the internal accumulator. `spike_acc` increments only if that bit was 0, so duplicates are idempotent.
- Address ≥ `N_SPIKES`: drop the event and set `err_addr_o`.
- `frame_end_i && enable_i`, on that clock edge:
  - `data_out_o <= acc_next`, where `acc_next` includes any event accepted in the same cycle. Bits [DATA_WIDTH-1:N_SPIKES] are always 0.
  - `spike_cnt_o <= cnt_next`.
  - Clear the accumulator and counter.
  - Go to SAMPLE.

SAMPLE:
- `sample_o = 1`, `spk_ready_o = 0`.
- Next state is WAIT_RDY unconditionally.

WAIT_RDY:
- `spk_ready_o = 0`.
- On `writer_ready_i == 1`: `frame_cnt_o++` (wraps at 2^CNT_W) and go to COLLECT.

Other rules:
- `frame_end_i` in SAMPLE or WAIT_RDY is ignored and sets `err_ovr_o`.
- `enable_i` low:
  - No events accepted and `frame_end_i` ignored; no error is flagged.
  - The accumulator is held.
  - An in-flight SAMPLE/WAIT_RDY still completes.
- `data_out_o` and `spike_cnt_o` stay stable from the SAMPLE cycle until the next frame-end edge.
- Sticky error flags clear only on reset.

## Timing

- Reset value of every output is 0. FSM resets to COLLECT; accumulator and counters reset to 0.
- `rst_i` mid-frame or in WAIT_RDY:
  - The partial frame is discarded.
  - No `sample_o` is emitted.
  - After release the block is in COLLECT.
- Latency: `frame_end_i` sampled at edge N gives `sample_o` and the new `data_out_o` valid during cycle N+1.
- `sample_o` is registered and exactly one cycle wide per frame.
- `writer_ready_i` is treated as 1 only in WAIT_RDY. The writer drops ready on the sample edge and raises it two edges later, so the minimum `spk_ready_o`-low window is 3 cycles.
- Back-to-back frames: the earliest next `frame_end_i` is accepted on the first COLLECT cycle after the return.

## Structure

- `spiker_adapter_pkg` (shared):
  - `collector_state_e` enum.
  - Defaults `N_SPIKES = 784`, `DATA_WIDTH = 800`.
- `spiker_adapter_reg_pkg` is unchanged.
- Single module: FSM, accumulator and counters. No sub-module is needed.
- Elaboration assertion: `DATA_WIDTH >= N_SPIKES`.

## Test plan

- **Reset:** assert `rst_i` mid-cycle. Every output reads 0 immediately; `busy_o = 0`; `spk_ready_o = 0` until release.
- **Basic frame:** events 0, 5, 783, then `frame_end_i`. `sample_o` high for one cycle, next cycle; `data_out_o` has bits 0, 5, 783 set and 0 elsewhere; `spike_cnt_o = 3`. Driving a writer model, `frame_cnt_o = 1` two cycles after `sample_o`.
- **Duplicates and out-of-range:** events 5, 5, 784, then frame end. Only bit 5 set; `spike_cnt_o = 1`; `err_addr_o = 1`.
- **Same-cycle:** event 10 together with `frame_end_i`. Bit 10 set in `data_out_o`; next frame's accumulator is empty (next frame with no events gives `data_out_o = 0`).
- **Backpressure:** hold `writer_ready_i = 0` for 20 cycles and pulse `frame_end_i` twice. `spk_ready_o = 0` throughout; `data_out_o` stable; `err_ovr_o = 1`; no second `sample_o`. Releasing ready returns the block to COLLECT with `frame_cnt_o` incremented.
- **Reset in WAIT_RDY:** all state cleared; a subsequent event at 7 plus frame end yields only bit 7 and `frame_cnt_o = 1`.
